// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Owns the architectural fetch PC. Issues in-order instruction-memory requests,
//   buffers the returned words and hands {pc, instr} to decode. A redirect from EX
//   reloads the PC, toggles the fetch epoch and flushes the buffer; responses whose
//   request was tagged with the old epoch are dropped when they come back.
//
// Ports
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   redirect_valid, redirect_pc   branch/jump redirect from EX
//   imem_req_valid/ready/addr     instruction-memory request channel
//   imem_rsp_valid/data           in-order response, no backpressure
//   if_valid/ready, if_pc/instr   delivery channel to decode
//   trap_misalign                 misaligned redirect seen (trap build only)
//
// Handshake semantics (both request and delivery channels): a transfer happens on a
// rising edge where valid and ready are both high; valid never depends on ready.
// Here valid may drop without a transfer only because of a redirect, which cancels
// the offered request/instruction in the same cycle.
//
// Build option: define MISALIGN_TRAP_EN to make a misaligned redirect halt fetch and
// raise trap_misalign; otherwise the low two bits of redirect_pc are masked off.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IBUF_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        trap_misalign
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef MISALIGN_TRAP_EN
    HALT = 2'd2,
`endif
    RUN  = 2'd1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc;
  logic          epoch;
  logic [OW-1:0] outstanding;

  // Tag FIFO: one entry per request in flight. Sized to IBUF_DEPTH (a power of two)
  // so the pointers wrap naturally; MAX_OUTSTANDING never exceeds it.
  logic [31:0]   tag_pc    [IBUF_DEPTH];
  logic          tag_epoch [IBUF_DEPTH];
  logic [PW-1:0] tag_wr, tag_rd;

  logic [31:0]   buf_pc    [IBUF_DEPTH];
  logic [31:0]   buf_instr [IBUF_DEPTH];
  logic [PW-1:0] buf_wr, buf_rd;
  logic [CW-1:0] buf_count;

  logic          run, misalign, redirect_take, flush, credit_ok;
  logic          req_fire, rsp_pop, rsp_keep, if_fire;
  logic [CW:0]   inflight;
  logic [31:0]   redirect_aligned;

  always_comb begin
    redirect_aligned = redirect_pc & ~32'h3;
    run              = (state_q == RUN);
`ifdef MISALIGN_TRAP_EN
    misalign         = run && redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    misalign         = 1'b0;
`endif
    redirect_take    = run && redirect_valid && !misalign;
    // Any redirect in RUN (taken or trapping) empties the buffer.
    flush            = run && redirect_valid;

    // Credit: every request in flight owns a buffer slot, so a response always fits.
    inflight         = (CW+1)'(outstanding) + {1'b0, buf_count};
    credit_ok        = (inflight < (CW+1)'(IBUF_DEPTH)) &&
                       (outstanding < OW'(MAX_OUTSTANDING));
    imem_req_valid   = run && !redirect_valid && credit_ok;
    imem_req_addr    = fetch_pc;
    req_fire         = imem_req_valid && imem_req_ready;

    // Responses always retire a tag; the word is kept only if it belongs to the
    // current epoch and no redirect is flushing the buffer this cycle.
    rsp_pop          = imem_rsp_valid && (outstanding != '0);
    rsp_keep         = rsp_pop && run && !redirect_valid && (tag_epoch[tag_rd] == epoch);

    if_valid         = (buf_count != '0) && !redirect_valid;
    if_pc            = buf_pc[buf_rd];
    if_instr         = buf_instr[buf_rd];
    if_fire          = if_valid && if_ready;

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN: begin
`ifdef MISALIGN_TRAP_EN
        if (misalign) state_d = HALT;
`endif
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      epoch       <= 1'b0;
      outstanding <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      buf_count   <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        tag_pc[i]    <= '0;
        tag_epoch[i] <= 1'b0;
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      if (redirect_take) begin
        fetch_pc <= redirect_aligned;
        epoch    <= ~epoch;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (req_fire) begin
        tag_pc[tag_wr]    <= fetch_pc;
        tag_epoch[tag_wr] <= epoch;
        tag_wr            <= tag_wr + PW'(1);
      end
      if (rsp_pop) begin
        tag_rd <= tag_rd + PW'(1);
      end
      outstanding <= outstanding + OW'(req_fire) - OW'(rsp_pop);

      if (flush) begin
        buf_wr    <= '0;
        buf_rd    <= '0;
        buf_count <= '0;
      end else begin
        if (rsp_keep) begin
          buf_pc[buf_wr]    <= tag_pc[tag_rd];
          buf_instr[buf_wr] <= imem_rsp_data;
          buf_wr            <= buf_wr + PW'(1);
        end
        if (if_fire) begin
          buf_rd <= buf_rd + PW'(1);
        end
        buf_count <= buf_count + CW'(rsp_keep) - CW'(if_fire);
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else if (misalign) begin
      trap_q <= 1'b1;
    end
  end

  assign trap_misalign = trap_q;
`else
  assign trap_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Bench for pc_fetch_unit. A small memory model answers requests in order one
//   cycle after acceptance (or later while held). Expected {pc, instr} pairs are
//   queued by the directed tests; a monitor pops and compares on every delivery.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        trap_misalign;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] vec[$];
  logic        mem_hold;
  int          base;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .trap_misalign  (trap_misalign)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // ---------------- memory model ----------------
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && !mem_hold && pend_q.size() > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_q.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend_q.push_back(imem_req_addr);
        req_log.push_back(imem_req_addr);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && if_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL if_unexpected act pc=%h instr=%h exp none", if_pc, if_instr);
        end else begin
          e = exp_q.pop_front();
          if ({if_pc, if_instr} !== e) begin
            errors++;
            $display("FAIL if_data act pc=%h instr=%h exp pc=%h instr=%h",
                     if_pc, if_instr, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cycle();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    mem_hold       = 1'b0;
    repeat (2) cycle();
    exp_q.delete();
    req_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic push_vec();
    for (int i = 0; i < vec.size(); i++) begin
      exp_q.push_back({vec[i], mem_word(vec[i])});
    end
  endtask

  task automatic check_req_vec(input string name, input int b);
    for (int i = 0; i < vec.size(); i++) begin
      logic [31:0] act;
      act = (b + i < req_log.size()) ? req_log[b + i] : 32'hDEAD_BEEF;
      check_val(name, act, vec[i]);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check_val(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    mem_hold       = 1'b0;
    base           = 0;

    // Reset values
    @(negedge clk);
    check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_val("rst_req_addr",  imem_req_addr,       32'h0000_0000);
    check_val("rst_if_valid",  32'(if_valid),       32'd0);
    check_val("rst_if_pc",     if_pc,               32'h0000_0000);
    check_val("rst_if_instr",  if_instr,            32'h0000_0000);
    check_val("rst_trap",      32'(trap_misalign),  32'd0);

    // 1: streaming fetch from reset
    do_reset();
    if_ready = 1'b1;
    vec = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    push_vec();
    @(negedge clk);
    check_val("t1_idle_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    check_val("t1_first_req",  32'(imem_req_valid), 32'd1);
    check_val("t1_first_addr", imem_req_addr,       32'h0000_0000);
    wait_drain("t1_drain", 100);
    if_ready = 1'b0;
    check_req_vec("t1_req", 0);

    // 2: decode stalled, buffer fills, then resumes in order
    do_reset();
    repeat (10) cycle();
    check_val("t2_req_count", 32'(req_log.size()), 32'd2);
    @(negedge clk);
    check_val("t2_full_no_req", 32'(imem_req_valid), 32'd0);
    check_val("t2_held_valid",  32'(if_valid),       32'd1);
    check_val("t2_held_pc",     if_pc,               32'h0000_0000);
    check_val("t2_held_instr",  if_instr,            32'h5A5A_0013);
    vec = '{32'h0, 32'h4, 32'h8, 32'hC};
    push_vec();
    cycle();
    if_ready = 1'b1;
    wait_drain("t2_drain", 100);
    if_ready = 1'b0;
    check_req_vec("t2_req", 0);

    // 3: redirect with two requests outstanding; stale words dropped
    do_reset();
    mem_hold = 1'b1;
    if_ready = 1'b1;
    repeat (5) cycle();
    check_val("t3_outstanding_reqs", 32'(req_log.size()), 32'd2);
    @(negedge clk);
    check_val("t3_cap_no_req", 32'(imem_req_valid), 32'd0);
    vec = '{32'h100, 32'h104, 32'h108};
    push_vec();
    cycle();
    mem_hold = 1'b0;
    cycle();
    base           = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    check_val("t3_redir_if_valid", 32'(if_valid),       32'd0);
    check_val("t3_redir_req",      32'(imem_req_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    wait_drain("t3_drain", 100);
    if_ready = 1'b0;
    check_req_vec("t3_req", base);

    // 4: back-to-back redirects over a full buffer; last target wins
    do_reset();
    repeat (8) cycle();
    vec = '{32'h300, 32'h304, 32'h308};
    push_vec();
    base           = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    if_ready       = 1'b1;
    @(negedge clk);
    check_val("t4_redir1_if_valid", 32'(if_valid),       32'd0);
    check_val("t4_redir1_req",      32'(imem_req_valid), 32'd0);
    cycle();
    redirect_pc = 32'h0000_0300;
    @(negedge clk);
    check_val("t4_redir2_if_valid", 32'(if_valid),       32'd0);
    check_val("t4_redir2_req",      32'(imem_req_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    wait_drain("t4_drain", 100);
    if_ready = 1'b0;
    check_req_vec("t4_req", base);

    // 5: fetch PC wraps past 0xFFFF_FFFC
    do_reset();
    repeat (3) cycle();
    vec = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    push_vec();
    base           = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    if_ready       = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    wait_drain("t5_drain", 100);
    if_ready = 1'b0;
    check_req_vec("t5_req", base);

    // 6: misaligned redirect target
    do_reset();
    repeat (3) cycle();
    base           = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    if_ready       = 1'b1;
`ifdef MISALIGN_TRAP_EN
    vec.delete();
    @(negedge clk);
    check_val("t6_redir_if_valid", 32'(if_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_val("t6_trap", 32'(trap_misalign), 32'd1);
    repeat (10) cycle();
    check_val("t6_no_reqs", 32'(req_log.size()), 32'(base));
    @(negedge clk);
    check_val("t6_halt_req",      32'(imem_req_valid), 32'd0);
    check_val("t6_halt_if_valid", 32'(if_valid),       32'd0);
    check_val("t6_trap_held",     32'(trap_misalign),  32'd1);
`else
    vec = '{32'h100, 32'h104, 32'h108};
    push_vec();
    @(negedge clk);
    check_val("t6_redir_if_valid", 32'(if_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    wait_drain("t6_drain", 100);
    if_ready = 1'b0;
    check_req_vec("t6_req", base);
    @(negedge clk);
    check_val("t6_trap_zero", 32'(trap_misalign), 32'd0);
`endif

    // ---------------- report ----------------
    repeat (2) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
